// File: rtl/load_store_unit_if.sv
// load_store_unit_if: data-memory request/response bus of the load/store unit.
//   mem_req   - request valid, held until mem_ready is sampled high
//   mem_we    - 1 = write, 0 = read
//   mem_be    - byte enables (bit n = byte lane n)
//   mem_addr  - word-aligned byte address
//   mem_wdata - lane-replicated store data
//   mem_ready - memory accepts/completes the current request
//   mem_rdata - read word, valid together with mem_ready on loads
// Modports: master = load/store unit side, slave = memory side.
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I execute-to-memory stage. Takes the ALU result as the
// effective address, steers byte lanes, replicates store data, sign/zero
// extends load data, and talks to data memory over a req/ready handshake with
// a timeout. stall holds the upstream pipeline while an access is in flight.
//
// Ports:
//   CLK, RESET        - clock, synchronous active-high reset
//   valid_in          - EX-stage op valid
//   is_load/is_store  - op kind (both set = illegal)
//   funct3            - RV32I width/sign code
//   addr, wdata       - effective address, store data
//   rd_in             - load destination register
//   stall             - hold upstream pipeline
//   mem               - memory bus (load_store_unit_if.master)
//   load_valid        - one-cycle pulse, load_data/load_rd valid
//   load_data, load_rd- extended load result and its destination
//   err               - one-cycle pulse: illegal op, timeout or misalignment
//
// Build option: MISALIGN_TRAP_EN. When defined, misaligned H/HU/W accesses
// raise err and issue no request. When undefined, such accesses are forced to
// natural alignment and proceed normally.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] RESET_ADDR_VAL = 32'h0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        valid_in,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd_in,
  output logic        stall,
  load_store_unit_if.master mem,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic [4:0]  load_rd,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_reg;
  logic        mem_req_reg, mem_we_reg;
  logic [3:0]  mem_be_reg;
  logic [31:0] mem_addr_reg, mem_wdata_reg;
  logic        load_valid_reg, err_reg;
  logic [31:0] load_data_reg;
  logic [4:0]  load_rd_reg;
  logic [15:0] timeout_cnt_reg;
  logic        op_is_load_reg, op_unsigned_reg;
  logic [1:0]  op_size_reg, op_lane_reg;

  // ---------------- request decode (IDLE) ----------------
  logic        op_sel, f3_legal, misaligned, go_busy, op_err;
  logic [1:0]  lane;
  logic [3:0]  be_next;
  logic [31:0] store_data;

  assign op_sel = valid_in & (is_load ^ is_store);

  always_comb begin
    f3_legal = 1'b0;
    if (is_load)
      f3_legal = (funct3 == 3'b000) | (funct3 == 3'b001) | (funct3 == 3'b010) |
                 (funct3 == 3'b100) | (funct3 == 3'b101);
    else
      f3_legal = (funct3 == 3'b000) | (funct3 == 3'b001) | (funct3 == 3'b010);
  end

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                      ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Lane offset after forcing natural alignment (H drops addr[0], W drops both).
  always_comb begin
    lane       = 2'b00;
    be_next    = 4'b1111;
    store_data = wdata;
    case (funct3[1:0])
      2'b00: begin
        lane       = addr[1:0];
        be_next    = 4'b0001 << addr[1:0];
        store_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        lane       = {addr[1], 1'b0};
        be_next    = 4'b0011 << {addr[1], 1'b0};
        store_data = {2{wdata[15:0]}};
      end
      default: begin
        lane       = 2'b00;
        be_next    = 4'b1111;
        store_data = wdata;
      end
    endcase
  end

  assign go_busy = (state_reg == IDLE) & op_sel & f3_legal & ~misaligned;
  assign op_err  = (state_reg == IDLE) & valid_in &
                   ((is_load & is_store) | (op_sel & (~f3_legal | misaligned)));

  // Illegal ops are not stalled: holding them upstream would only repeat the error.
  assign stall = (state_reg == BUSY) | go_busy;

  // ---------------- load extraction ----------------
  logic [31:0] rdata_shifted, load_ext;

  assign rdata_shifted = mem.mem_rdata >> {op_lane_reg, 3'b000};

  always_comb begin
    load_ext = mem.mem_rdata;
    case (op_size_reg)
      2'b00:   load_ext = op_unsigned_reg ? {24'h0, rdata_shifted[7:0]}
                                          : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      2'b01:   load_ext = op_unsigned_reg ? {16'h0, rdata_shifted[15:0]}
                                          : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: load_ext = mem.mem_rdata;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg       <= IDLE;
      mem_req_reg     <= 1'b0;
      mem_we_reg      <= 1'b0;
      mem_be_reg      <= 4'b0000;
      mem_addr_reg    <= RESET_ADDR_VAL;
      mem_wdata_reg   <= 32'h0;
      load_valid_reg  <= 1'b0;
      load_data_reg   <= 32'h0;
      load_rd_reg     <= 5'd0;
      err_reg         <= 1'b0;
      timeout_cnt_reg <= 16'd0;
      op_is_load_reg  <= 1'b0;
      op_unsigned_reg <= 1'b0;
      op_size_reg     <= 2'b00;
      op_lane_reg     <= 2'b00;
    end else begin
      load_valid_reg <= 1'b0;
      err_reg        <= 1'b0;
      case (state_reg)
        IDLE: begin
          err_reg <= op_err;
          if (go_busy) begin
            state_reg       <= BUSY;
            mem_req_reg     <= 1'b1;
            mem_we_reg      <= is_store;
            mem_be_reg      <= be_next;
            mem_addr_reg    <= {addr[31:2], 2'b00};
            mem_wdata_reg   <= store_data;
            timeout_cnt_reg <= 16'd0;
            op_is_load_reg  <= is_load;
            op_unsigned_reg <= funct3[2];
            op_size_reg     <= funct3[1:0];
            op_lane_reg     <= lane;
            load_rd_reg     <= is_load ? rd_in : load_rd_reg;
          end
        end
        BUSY: begin
          if (mem.mem_ready) begin
            mem_req_reg <= 1'b0;
            if (op_is_load_reg) begin
              load_data_reg  <= load_ext;
              load_valid_reg <= 1'b1;
              state_reg      <= DONE;
            end else begin
              state_reg <= IDLE;
            end
          end else if (timeout_cnt_reg == 16'(TIMEOUT_CYCLES - 1)) begin
            mem_req_reg     <= 1'b0;
            err_reg         <= 1'b1;
            timeout_cnt_reg <= 16'd0;
            state_reg       <= IDLE;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 16'd1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mem.mem_req   = mem_req_reg;
  assign mem.mem_we    = mem_we_reg;
  assign mem.mem_be    = mem_be_reg;
  assign mem.mem_addr  = mem_addr_reg;
  assign mem.mem_wdata = mem_wdata_reg;
  assign load_valid    = load_valid_reg;
  assign load_data     = load_data_reg;
  assign load_rd       = load_rd_reg;
  assign err           = err_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit (TIMEOUT_CYCLES = 4).
// Expected load results are queued when a load is issued and popped by a
// monitor whenever the DUT pulses load_valid.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        valid_in, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [4:0]  rd_in;
  logic        stall, load_valid, err;
  logic [31:0] load_data;
  logic [4:0]  load_rd;

  load_store_unit_if mem_bus ();

  load_store_unit #(.TIMEOUT_CYCLES(4), .RESET_ADDR_VAL(32'h0)) dut (
    .CLK(clk), .RESET(rst), .valid_in(valid_in), .is_load(is_load),
    .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata),
    .rd_in(rd_in), .stall(stall), .mem(mem_bus), .load_valid(load_valid),
    .load_data(load_data), .load_rd(load_rd), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every load_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (load_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_load_valid", {31'h0, load_valid}, 32'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("load_data", load_data, e.data);
        chk("load_rd", {27'h0, load_rd}, {27'h0, e.rd});
      end
    end
  end

  task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    valid_in = 1'b1; is_load = ld; is_store = st;
    funct3 = f3; addr = a; wdata = wd; rd_in = rd;
  endtask

  task automatic clear_op();
    valid_in = 1'b0; is_load = 1'b0; is_store = 1'b0;
  endtask

  // Cycle 0: present a legal op; stall must rise combinationally, no request yet.
  task automatic accept(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    drive_op(ld, st, f3, a, wd, rd);
    @(negedge clk);
    chk({tag, "_stall_c0"}, {31'h0, stall}, 32'h1);
    chk({tag, "_req_c0"}, {31'h0, mem_bus.mem_req}, 32'h0);
    @(posedge clk); #1;
    clear_op();
  endtask

  // BUSY cycles: bus fields held stable for 'delay' cycles without ready, then ready.
  task automatic respond(input string tag, input logic we, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int delay, input logic [31:0] rdata);
    for (int i = 0; i <= delay; i++) begin
      if (i == delay) begin
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = rdata;
      end
      @(negedge clk);
      chk({tag, "_req"}, {31'h0, mem_bus.mem_req}, 32'h1);
      chk({tag, "_stall"}, {31'h0, stall}, 32'h1);
      if (i == 0 || i == delay) begin
        chk({tag, "_we"}, {31'h0, mem_bus.mem_we}, {31'h0, we});
        chk({tag, "_be"}, {28'h0, mem_bus.mem_be}, {28'h0, be});
        chk({tag, "_addr"}, mem_bus.mem_addr, a);
        if (we) chk({tag, "_wdata"}, mem_bus.mem_wdata, wd);
      end
      @(posedge clk); #1;
    end
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = 32'h0;
  endtask

  task automatic store_done(input string tag);
    @(negedge clk);
    chk({tag, "_req_done"}, {31'h0, mem_bus.mem_req}, 32'h0);
    chk({tag, "_stall_done"}, {31'h0, stall}, 32'h0);
    chk({tag, "_err_done"}, {31'h0, err}, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic load_done(input string tag);
    @(negedge clk);
    chk({tag, "_lv_pulse"}, {31'h0, load_valid}, 32'h1);
    chk({tag, "_stall_done"}, {31'h0, stall}, 32'h0);
    chk({tag, "_req_done"}, {31'h0, mem_bus.mem_req}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_lv_low"}, {31'h0, load_valid}, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic load_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [4:0] rd, input logic [3:0] be, input logic [31:0] wa,
                         input int delay, input logic [31:0] rdata, input logic [31:0] exp_data);
    exp_t e;
    e.data = exp_data;
    e.rd   = rd;
    sb_q.push_back(e);
    accept(tag, 1'b1, 1'b0, f3, a, 32'h0, rd);
    respond(tag, 1'b0, be, wa, 32'h0, delay, rdata);
    load_done(tag);
  endtask

  // Illegal op: err one cycle later, no request, no stall.
  task automatic err_op(input string tag, input logic ld, input logic st,
                        input logic [2:0] f3, input logic [31:0] a);
    drive_op(ld, st, f3, a, 32'h12345678, 5'd1);
    @(negedge clk);
    chk({tag, "_stall"}, {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    clear_op();
    @(negedge clk);
    chk({tag, "_err"}, {31'h0, err}, 32'h1);
    chk({tag, "_req"}, {31'h0, mem_bus.mem_req}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_err_low"}, {31'h0, err}, 32'h0);
    chk({tag, "_req_low"}, {31'h0, mem_bus.mem_req}, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    clear_op();
    funct3 = 3'b000; addr = 32'h0; wdata = 32'h0; rd_in = 5'd0;
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_req", {31'h0, mem_bus.mem_req}, 32'h0);
    chk("rst_we", {31'h0, mem_bus.mem_we}, 32'h0);
    chk("rst_be", {28'h0, mem_bus.mem_be}, 32'h0);
    chk("rst_addr", mem_bus.mem_addr, 32'h0);
    chk("rst_wdata", mem_bus.mem_wdata, 32'h0);
    chk("rst_lv", {31'h0, load_valid}, 32'h0);
    chk("rst_ldata", load_data, 32'h0);
    chk("rst_lrd", {27'h0, load_rd}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;

    // SW with mem_ready already high in IDLE (must be ignored there)
    mem_bus.mem_ready = 1'b1;
    accept("sw", 1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0);
    respond("sw", 1'b1, 4'b1111, 32'h100, 32'hDEADBEEF, 0, 32'h0);
    store_done("sw");

    // LB sign-extended, ready delayed 3 cycles
    load_op("lb", 3'b000, 32'h203, 5'd7, 4'b1000, 32'h200, 3, 32'h80112233, 32'hFFFFFF80);
    // Byte lanes 1 and 2, unsigned and signed
    load_op("lbu", 3'b100, 32'h201, 5'd2, 4'b0010, 32'h200, 1, 32'h80112233, 32'h00000022);
    load_op("lb2", 3'b000, 32'h202, 5'd5, 4'b0100, 32'h200, 0, 32'h80112233, 32'h00000011);
    // Upper halfword, zero- and sign-extended
    load_op("lhu", 3'b101, 32'h202, 5'd3, 4'b1100, 32'h200, 0, 32'h9ABC1234, 32'h00009ABC);
    load_op("lh", 3'b001, 32'h202, 5'd4, 4'b1100, 32'h200, 2, 32'h9ABC1234, 32'hFFFF9ABC);
    load_op("lh_lo", 3'b001, 32'h200, 5'd6, 4'b0011, 32'h200, 0, 32'h9ABC8234, 32'hFFFF8234);

    // SB lane 1 replication
    accept("sb", 1'b0, 1'b1, 3'b000, 32'h11, 32'h000000A5, 5'd0);
    respond("sb", 1'b1, 4'b0010, 32'h10, 32'hA5A5A5A5, 1, 32'h0);
    store_done("sb");

    // SH upper half replication
    accept("sh", 1'b0, 1'b1, 3'b001, 32'h6, 32'h1234BEEF, 5'd0);
    respond("sh", 1'b1, 4'b1100, 32'h4, 32'hBEEFBEEF, 0, 32'h0);
    store_done("sh");

    // Timeout: 4 BUSY cycles with no ready, then err and mem_req drops
    accept("tmo", 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd9);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("tmo_req_busy", {31'h0, mem_bus.mem_req}, 32'h1);
      chk("tmo_err_busy", {31'h0, err}, 32'h0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("tmo_err", {31'h0, err}, 32'h1);
    chk("tmo_req", {31'h0, mem_bus.mem_req}, 32'h0);
    chk("tmo_stall", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("tmo_err_low", {31'h0, err}, 32'h0);
    @(posedge clk); #1;

    // Reset in the middle of a BUSY load
    accept("rstmid", 1'b1, 1'b0, 3'b010, 32'h80, 32'h0, 5'd4);
    @(negedge clk);
    chk("rstmid_req_busy", {31'h0, mem_bus.mem_req}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("rstmid_req", {31'h0, mem_bus.mem_req}, 32'h0);
    chk("rstmid_stall", {31'h0, stall}, 32'h0);
    chk("rstmid_addr", mem_bus.mem_addr, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = 32'h0;
    @(negedge clk);
    chk("rstmid_lv", {31'h0, load_valid}, 32'h0);
    @(posedge clk); #1;

    // Misaligned LW at 0x102
`ifdef MISALIGN_TRAP_EN
    err_op("lw_mis", 1'b1, 1'b0, 3'b010, 32'h102);
    err_op("lh_mis", 1'b1, 1'b0, 3'b101, 32'h203);
`else
    load_op("lw_mis", 3'b010, 32'h102, 5'd8, 4'b1111, 32'h100, 0, 32'h11223344, 32'h11223344);
    load_op("lhu_mis", 3'b101, 32'h203, 5'd10, 4'b1100, 32'h200, 0, 32'h9ABC1234, 32'h00009ABC);
`endif

    // Illegal encodings
    err_op("ld_f011", 1'b1, 1'b0, 3'b011, 32'h100);
    err_op("ld_f110", 1'b1, 1'b0, 3'b110, 32'h100);
    err_op("st_f100", 1'b0, 1'b1, 3'b100, 32'h100);
    err_op("ld_and_st", 1'b1, 1'b1, 3'b010, 32'h100);

    // A legal load still works after the error cases
    load_op("lw_after", 3'b010, 32'h300, 5'd31, 4'b1111, 32'h300, 0, 32'hA5A55A5A, 32'hA5A55A5A);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
